nios_ii_nios2_qsys_0_oci_dct_ctrl: RTL and testbench

- Sequencer for the OCI debug capture trace (DCT) buffer: packs 2-bit trace atoms from the CPU trace port into a 30-bit fill buffer with an atom count.
- Hands completed or flushed frames to the downstream trace store over a valid/ready handshake.
- Sequences end-of-test: final flush, drain, then the ended indication.
- Exposes the live dct_buffer/dct_count to the OCI test bench monitor.

---
 rtl/nios_ii_nios2_qsys_0_oci_dct_ctrl.sv | 177 +++++++++++++++++
 tb/tb_nios_ii_nios2_qsys_0_oci_dct_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/nios_ii_nios2_qsys_0_oci_dct_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : nios_ii_nios2_qsys_0_oci_dct_ctrl
// Description : OCI debug capture trace sequencer; packs trace atoms into
//               frames, hands them downstream and sequences end-of-test.
// Revision    : 1.0
// ============================================================================
module nios_ii_nios2_qsys_0_oci_dct_ctrl #(
    parameter int ATOM_W = 2,
    parameter int ATOMS  = 15,
    parameter int CNT_W  = 4,
    parameter int DROP_W = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      atom_valid,
    input  logic [ATOM_W-1:0]         atom,
    output logic                      atom_ready,
    input  logic                      flush,
    input  logic                      test_ending,
    output logic                      frame_valid,
    output logic [ATOM_W*ATOMS-1:0]   frame_data,
    output logic [CNT_W-1:0]          frame_count,
    input  logic                      frame_ready,
    output logic [ATOM_W*ATOMS-1:0]   dct_buffer,
    output logic [CNT_W-1:0]          dct_count,
    output logic [DROP_W-1:0]         drop_count,
    input  logic                      drop_clr,
    output logic                      test_has_ended
);

    localparam int               c_buf_w = ATOM_W * ATOMS;
    localparam logic [CNT_W-1:0] c_full  = CNT_W'(ATOMS);

    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_FLUSH_END = 2'd1,
        ST_DRAIN     = 2'd2,
        ST_ENDED     = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [c_buf_w-1:0]   buf_q, buf_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 frame_valid_q, frame_valid_d;
    logic [c_buf_w-1:0]   frame_data_q, frame_data_d;
    logic [CNT_W-1:0]     frame_count_q, frame_count_d;
    logic [DROP_W-1:0]    drop_q, drop_d;
    logic                 flush_pend_q, flush_pend_d;
    logic                 ended_q, ended_d;

    logic w_ofree;
    logic w_ending;
    logic w_full;
    logic w_atom_ready;
    logic w_accept;
    logic w_flush_req;
    logic w_xfer;

    always_comb begin
        w_ofree      = !frame_valid_q | frame_ready;
        w_ending     = (state_q != ST_RUN);
        w_full       = (cnt_q == c_full);
        w_atom_ready = !(w_full & !w_ofree) & !w_ending;
        w_accept     = atom_valid & w_atom_ready;
        // FLUSH_END behaves as a flush held high until the buffer empties.
        w_flush_req  = (flush & (state_q == ST_RUN)) | flush_pend_q |
                       (state_q == ST_FLUSH_END);
        w_xfer       = w_ofree & (w_full | (w_flush_req & (cnt_q != '0)));
    end

    always_comb begin
        buf_d = buf_q;
        cnt_d = cnt_q;
        if (w_xfer) begin
            buf_d = '0;
            cnt_d = '0;
        end
        // An atom arriving with a transfer starts the freshly cleared buffer.
        if (w_accept) begin
            if (w_xfer) begin
                buf_d              = '0;
                buf_d[ATOM_W-1:0]  = atom;
                cnt_d              = CNT_W'(1);
            end else begin
                buf_d = {buf_q[c_buf_w-ATOM_W-1:0], atom};
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_comb begin
        frame_valid_d = frame_valid_q;
        frame_data_d  = frame_data_q;
        frame_count_d = frame_count_q;
        if (w_xfer) begin
            frame_valid_d = 1'b1;
            frame_data_d  = buf_q;
            frame_count_d = cnt_q;
        end else if (frame_valid_q & frame_ready) begin
            frame_valid_d = 1'b0;
        end
    end

    always_comb begin
        drop_d = drop_q;
        if (drop_clr) begin
            drop_d = '0;
        end else if (atom_valid & !w_atom_ready & !w_ending & (drop_q != '1)) begin
            drop_d = drop_q + DROP_W'(1);
        end
    end

    always_comb begin
        flush_pend_d = ((flush & (state_q == ST_RUN)) | flush_pend_q) &
                       !w_xfer & (cnt_q != '0);
    end

    // Transitions look at next-cycle occupancy so an idle end-of-test
    // completes without an extra bubble.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (test_ending) state_d = ST_FLUSH_END;
            end
            ST_FLUSH_END: begin
                if (cnt_d == '0) state_d = frame_valid_d ? ST_DRAIN : ST_ENDED;
            end
            ST_DRAIN: begin
                if (!frame_valid_d) state_d = ST_ENDED;
            end
            ST_ENDED: begin
                state_d = ST_ENDED;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
        ended_d = (state_d == ST_ENDED);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_RUN;
            buf_q         <= '0;
            cnt_q         <= '0;
            frame_valid_q <= 1'b0;
            frame_data_q  <= '0;
            frame_count_q <= '0;
            drop_q        <= '0;
            flush_pend_q  <= 1'b0;
            ended_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            buf_q         <= buf_d;
            cnt_q         <= cnt_d;
            frame_valid_q <= frame_valid_d;
            frame_data_q  <= frame_data_d;
            frame_count_q <= frame_count_d;
            drop_q        <= drop_d;
            flush_pend_q  <= flush_pend_d;
            ended_q       <= ended_d;
        end
    end

    assign atom_ready     = w_atom_ready;
    assign frame_valid    = frame_valid_q;
    assign frame_data     = frame_data_q;
    assign frame_count    = frame_count_q;
    assign dct_buffer     = buf_q;
    assign dct_count      = cnt_q;
    assign drop_count     = drop_q;
    assign test_has_ended = ended_q;

endmodule
`default_nettype wire

// File: tb/tb_nios_ii_nios2_qsys_0_oci_dct_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_nios_ii_nios2_qsys_0_oci_dct_ctrl
// Description : Directed self-checking bench for the DCT sequencer.
// Revision    : 1.0
// ============================================================================
module tb_nios_ii_nios2_qsys_0_oci_dct_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        atom_valid;
    logic [1:0]  atom;
    logic        atom_ready;
    logic        flush;
    logic        test_ending;
    logic        frame_valid;
    logic [29:0] frame_data;
    logic [3:0]  frame_count;
    logic        frame_ready;
    logic [29:0] dct_buffer;
    logic [3:0]  dct_count;
    logic [7:0]  drop_count;
    logic        drop_clr;
    logic        test_has_ended;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    nios_ii_nios2_qsys_0_oci_dct_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .atom_valid     (atom_valid),
        .atom           (atom),
        .atom_ready     (atom_ready),
        .flush          (flush),
        .test_ending    (test_ending),
        .frame_valid    (frame_valid),
        .frame_data     (frame_data),
        .frame_count    (frame_count),
        .frame_ready    (frame_ready),
        .dct_buffer     (dct_buffer),
        .dct_count      (dct_count),
        .drop_count     (drop_count),
        .drop_clr       (drop_clr),
        .test_has_ended (test_has_ended)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; atom_valid = 1'b0; atom = 2'b00; flush = 1'b0;
        test_ending = 1'b0; frame_ready = 1'b0; drop_clr = 1'b0;
        tick(); tick();
        total++; if (dct_count !== 4'd0) begin bad++; $display("FAIL reset_dct_count got %0d want 0", dct_count); end
        total++; if (dct_buffer !== 30'h0) begin bad++; $display("FAIL reset_dct_buffer got %h want 0", dct_buffer); end
        total++; if (frame_valid !== 1'b0) begin bad++; $display("FAIL reset_frame_valid got %b want 0", frame_valid); end
        total++; if (drop_count !== 8'd0) begin bad++; $display("FAIL reset_drop_count got %0d want 0", drop_count); end
        total++; if (test_has_ended !== 1'b0) begin bad++; $display("FAIL reset_ended got %b want 0", test_has_ended); end
        reset = 1'b0;
        tick();
        total++; if (atom_ready !== 1'b1) begin bad++; $display("FAIL reset_atom_ready got %b want 1", atom_ready); end
    endtask

    task automatic test_full_frame();
        logic [29:0] exp = '0;
        frame_ready = 1'b1;
        for (int i = 0; i < 15; i++) begin
            atom_valid = 1'b1; atom = 2'(i % 4);
            exp = {exp[27:0], atom};
            tick();
        end
        atom_valid = 1'b0;
        total++; if (dct_count !== 4'd15) begin bad++; $display("FAIL full_count15 got %0d want 15", dct_count); end
        tick();
        total++; if (frame_valid !== 1'b1) begin bad++; $display("FAIL full_frame_valid got %b want 1", frame_valid); end
        total++; if (frame_count !== 4'd15) begin bad++; $display("FAIL full_frame_count got %0d want 15", frame_count); end
        total++; if (frame_data !== exp) begin bad++; $display("FAIL full_frame_data got %h want %h", frame_data, exp); end
        total++; if (frame_data[29:28] !== 2'b00 || frame_data[1:0] !== 2'b10) begin bad++; $display("FAIL full_frame_ends got %h want msb 0 lsb 2", frame_data); end
        total++; if (dct_count !== 4'd0) begin bad++; $display("FAIL full_dct_cleared got %0d want 0", dct_count); end
        tick();
    endtask

    task automatic test_flush();
        logic [1:0] seq [3] = '{2'd3, 2'd2, 2'd1};
        frame_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            atom_valid = 1'b1; atom = seq[i];
            tick();
        end
        atom_valid = 1'b0; flush = 1'b1;
        tick();
        flush = 1'b0;
        total++; if (frame_valid !== 1'b1) begin bad++; $display("FAIL flush_valid got %b want 1", frame_valid); end
        total++; if (frame_count !== 4'd3) begin bad++; $display("FAIL flush_count got %0d want 3", frame_count); end
        total++; if (frame_data !== 30'h39) begin bad++; $display("FAIL flush_data got %h want 39", frame_data); end
        tick();
        total++; if (frame_valid !== 1'b0) begin bad++; $display("FAIL flush_pop got %b want 0", frame_valid); end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        total++; if (frame_valid !== 1'b0) begin bad++; $display("FAIL flush_empty got %b want 0", frame_valid); end
        tick();
        total++; if (frame_valid !== 1'b0) begin bad++; $display("FAIL flush_empty_late got %b want 0", frame_valid); end
    endtask

    task automatic test_backpressure();
        logic [29:0] exp1 = '0;
        logic [29:0] exp2 = '0;
        frame_ready = 1'b0;
        for (int i = 0; i < 31; i++) begin
            atom_valid = 1'b1; atom = 2'((i * 3 + 1) % 4);
            if (i < 15) exp1 = {exp1[27:0], atom};
            else if (i < 30) exp2 = {exp2[27:0], atom};
            if (i == 30) begin
                total++; if (atom_ready !== 1'b0) begin bad++; $display("FAIL bp_atom_ready got %b want 0", atom_ready); end
            end
            tick();
        end
        atom_valid = 1'b0;
        total++; if (frame_valid !== 1'b1 || frame_data !== exp1) begin bad++; $display("FAIL bp_frame_held got %b/%h want 1/%h", frame_valid, frame_data, exp1); end
        total++; if (dct_count !== 4'd15 || dct_buffer !== exp2) begin bad++; $display("FAIL bp_second_fill got %0d/%h want 15/%h", dct_count, dct_buffer, exp2); end
        total++; if (drop_count !== 8'd1) begin bad++; $display("FAIL bp_drop got %0d want 1", drop_count); end
        drop_clr = 1'b1;
        tick();
        drop_clr = 1'b0;
        total++; if (drop_count !== 8'd0) begin bad++; $display("FAIL bp_drop_clr got %0d want 0", drop_count); end
        frame_ready = 1'b1;
        tick();
        total++; if (frame_data !== exp2 || frame_count !== 4'd15 || dct_count !== 4'd0) begin bad++; $display("FAIL bp_b2b got %h/%0d/%0d want %h/15/0", frame_data, frame_count, dct_count, exp2); end
        tick();
        total++; if (frame_valid !== 1'b0) begin bad++; $display("FAIL bp_drain got %b want 0", frame_valid); end
    endtask

    task automatic test_back_to_back();
        logic [29:0] exp = '0;
        frame_ready = 1'b1;
        for (int i = 0; i < 15; i++) begin
            atom_valid = 1'b1; atom = 2'(3 - (i % 4));
            exp = {exp[27:0], atom};
            tick();
        end
        atom = 2'b01;
        tick();
        atom_valid = 1'b0;
        total++; if (frame_count !== 4'd15 || frame_data !== exp) begin bad++; $display("FAIL b2b_frame got %0d/%h want 15/%h", frame_count, frame_data, exp); end
        total++; if (dct_count !== 4'd1 || dct_buffer !== 30'h1) begin bad++; $display("FAIL b2b_buffer got %0d/%h want 1/1", dct_count, dct_buffer); end
        total++; if (drop_count !== 8'd0) begin bad++; $display("FAIL b2b_drop got %0d want 0", drop_count); end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        total++; if (frame_count !== 4'd1 || frame_data !== 30'h1) begin bad++; $display("FAIL b2b_flush got %0d/%h want 1/1", frame_count, frame_data); end
        tick();
    endtask

    task automatic test_end_of_test();
        logic [29:0] exp = '0;
        logic [1:0]  seq [5] = '{2'd2, 2'd1, 2'd3, 2'd0, 2'd2};
        frame_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            atom_valid = 1'b1; atom = seq[i];
            exp = {exp[27:0], atom};
            tick();
        end
        atom_valid = 1'b0; test_ending = 1'b1;
        tick();
        test_ending = 1'b0;
        total++; if (atom_ready !== 1'b0) begin bad++; $display("FAIL end_atom_ready got %b want 0", atom_ready); end
        tick();
        total++; if (frame_valid !== 1'b1 || frame_count !== 4'd5 || frame_data !== exp) begin bad++; $display("FAIL end_partial got %b/%0d/%h want 1/5/%h", frame_valid, frame_count, frame_data, exp); end
        repeat (4) tick();
        total++; if (frame_valid !== 1'b1 || test_has_ended !== 1'b0) begin bad++; $display("FAIL end_drain_wait got %b/%b want 1/0", frame_valid, test_has_ended); end
        frame_ready = 1'b1;
        tick();
        total++; if (frame_valid !== 1'b0 || test_has_ended !== 1'b1) begin bad++; $display("FAIL end_ended got %b/%b want 0/1", frame_valid, test_has_ended); end
        frame_ready = 1'b0; atom_valid = 1'b1; atom = 2'b11; flush = 1'b1;
        repeat (5) tick();
        atom_valid = 1'b0; flush = 1'b0;
        total++; if (drop_count !== 8'd0 || dct_count !== 4'd0 || frame_valid !== 1'b0) begin bad++; $display("FAIL end_ignored got %0d/%0d/%b want 0/0/0", drop_count, dct_count, frame_valid); end
        total++; if (test_has_ended !== 1'b1) begin bad++; $display("FAIL end_sticky got %b want 1", test_has_ended); end
    endtask

    task automatic test_async_reset();
        logic [29:0] exp = '0;
        reset = 1'b1; tick(); reset = 1'b0; tick();
        frame_ready = 1'b0;
        for (int i = 0; i < 22; i++) begin
            atom_valid = 1'b1; atom = 2'(i % 3);
            tick();
        end
        atom_valid = 1'b0;
        total++; if (dct_count !== 4'd7 || frame_valid !== 1'b1) begin bad++; $display("FAIL ar_setup got %0d/%b want 7/1", dct_count, frame_valid); end
        #2 reset = 1'b1;
        #1;
        total++; if (dct_count !== 4'd0 || dct_buffer !== 30'h0 || frame_valid !== 1'b0) begin bad++; $display("FAIL ar_fill_clear got %0d/%h/%b want 0/0/0", dct_count, dct_buffer, frame_valid); end
        total++; if (frame_data !== 30'h0 || frame_count !== 4'd0 || test_has_ended !== 1'b0) begin bad++; $display("FAIL ar_frame_clear got %h/%0d/%b want 0/0/0", frame_data, frame_count, test_has_ended); end
        tick();
        reset = 1'b0;
        frame_ready = 1'b1;
        for (int i = 0; i < 15; i++) begin
            atom_valid = 1'b1; atom = 2'((i + 2) % 4);
            exp = {exp[27:0], atom};
            tick();
        end
        atom_valid = 1'b0;
        tick();
        total++; if (frame_count !== 4'd15 || frame_data !== exp) begin bad++; $display("FAIL ar_resume got %0d/%h want 15/%h", frame_count, frame_data, exp); end
        tick(); tick();
        test_ending = 1'b1;
        tick();
        test_ending = 1'b0;
        total++; if (test_has_ended !== 1'b0) begin bad++; $display("FAIL ar_idle_end_early got %b want 0", test_has_ended); end
        tick();
        total++; if (test_has_ended !== 1'b1) begin bad++; $display("FAIL ar_idle_end got %b want 1", test_has_ended); end
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_flush();
        test_backpressure();
        test_back_to_back();
        test_end_of_test();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

endmodule
`default_nettype wire
